// File: rtl/hbmc_dfifo_pkg.sv
// Shared types and constants for the HyperBus downstream data FIFO.
package hbmc_dfifo_pkg;

    typedef enum logic {
        WORD_LS_FIRST = 1'b0,
        WORD_MS_FIRST = 1'b1
    } word_order_e;

    localparam int HB_WORD_W = 16;
    localparam int HB_STRB_W = 2;

endpackage

// File: rtl/hbmc_sync_fifo_mem.sv
// Single-clock register-array FIFO: pointers, fill level, full/empty and synchronous flush.
module hbmc_sync_fifo_mem #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic                       clk_i,
    input  logic                       arst_i,
    input  logic                       flush_i,
    input  logic                       push_i,
    input  logic                       pop_i,
    input  logic [WIDTH-1:0]           wdata_i,
    output logic [WIDTH-1:0]           rdata_o,
    output logic [$clog2(DEPTH):0]     level_o,
    output logic                       full_o,
    output logic                       empty_o
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wptr_q, wptr_d;
    logic [AW-1:0]    rptr_q, rptr_d;
    logic [LW-1:0]    level_q, level_d;
    logic             push, pop;

    // Full/empty come from the registered level, so a push into a full FIFO is
    // dropped even when the head is popped in the same cycle.
    assign full_o  = (level_q == LW'(DEPTH));
    assign empty_o = (level_q == '0);
    assign push    = push_i & ~full_o & ~flush_i;
    assign pop     = pop_i & ~empty_o & ~flush_i;
    assign rdata_o = mem_q[rptr_q];
    assign level_o = level_q;

    always_comb begin
        wptr_d  = wptr_q;
        rptr_d  = rptr_q;
        level_d = level_q;
        if (flush_i) begin
            wptr_d  = '0;
            rptr_d  = '0;
            level_d = '0;
        end else begin
            if (push) wptr_d = wptr_q + AW'(1);
            if (pop)  rptr_d = rptr_q + AW'(1);
            case ({push, pop})
                2'b10:   level_d = level_q + LW'(1);
                2'b01:   level_d = level_q - LW'(1);
                default: level_d = level_q;
            endcase
        end
    end

    always_ff @(posedge clk_i or posedge arst_i) begin
        if (arst_i) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            level_q <= '0;
        end else begin
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            level_q <= level_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (push) mem_q[wptr_q] <= wdata_i;
    end

endmodule

// File: rtl/hbmc_dfifo_sc.sv
// Downstream data FIFO: stores wide write beats and presents them first-word-fall-through
// as 16-bit HyperBus words with 2-bit strobes and an end-of-beat marker.
module hbmc_dfifo_sc
    import hbmc_dfifo_pkg::*;
#(
    parameter int          DATA_WIDTH   = 32,
    parameter int          FIFO_DEPTH   = 16,
    parameter int          AFULL_THRESH = FIFO_DEPTH - 2,
    parameter word_order_e WORD_ORDER   = WORD_LS_FIRST
) (
    input  logic                            fifo_clk,
    input  logic                            fifo_arst,
    input  logic                            fifo_flush,
    input  logic [DATA_WIDTH-1:0]           fifo_wr_din,
    input  logic [DATA_WIDTH/8-1:0]         fifo_wr_strb,
    input  logic                            fifo_wr_ena,
    output logic                            fifo_wr_full,
    output logic                            fifo_wr_afull,
    output logic [$clog2(FIFO_DEPTH):0]     fifo_wr_level,
    output logic [HB_WORD_W-1:0]            fifo_rd_dout,
    output logic [HB_STRB_W-1:0]            fifo_rd_strb,
    output logic                            fifo_rd_last,
    input  logic                            fifo_rd_ena,
    output logic                            fifo_rd_empty
);

    localparam int N   = DATA_WIDTH / HB_WORD_W;
    localparam int WCW = (N > 1) ? $clog2(N) : 1;
    localparam int LW  = $clog2(FIFO_DEPTH) + 1;
    localparam int SW  = DATA_WIDTH / 8;
    localparam int EW  = DATA_WIDTH + SW;

    if ((DATA_WIDTH % 16) != 0 || DATA_WIDTH < 16 || DATA_WIDTH > 128) begin : g_bad_width
        $error("hbmc_dfifo_sc: DATA_WIDTH must be a multiple of 16 in 16..128");
    end
    if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
        $error("hbmc_dfifo_sc: FIFO_DEPTH must be a power of 2, at least 2");
    end
    if (AFULL_THRESH > FIFO_DEPTH) begin : g_bad_afull
        $error("hbmc_dfifo_sc: AFULL_THRESH must not exceed FIFO_DEPTH");
    end

    logic [EW-1:0]         head;
    logic [DATA_WIDTH-1:0] head_din;
    logic [SW-1:0]         head_strb;
    logic [WCW-1:0]        wcnt_q, wcnt_d;
    logic [WCW-1:0]        sel;
    logic                  wcnt_last;
    logic                  rd_fire;
    logic                  pop;

    hbmc_sync_fifo_mem #(
        .WIDTH (EW),
        .DEPTH (FIFO_DEPTH)
    ) u_mem (
        .clk_i   (fifo_clk),
        .arst_i  (fifo_arst),
        .flush_i (fifo_flush),
        .push_i  (fifo_wr_ena),
        .pop_i   (pop),
        .wdata_i ({fifo_wr_strb, fifo_wr_din}),
        .rdata_o (head),
        .level_o (fifo_wr_level),
        .full_o  (fifo_wr_full),
        .empty_o (fifo_rd_empty)
    );

    assign head_din      = head[DATA_WIDTH-1:0];
    assign head_strb     = head[EW-1:DATA_WIDTH];
    assign wcnt_last     = (wcnt_q == WCW'(N - 1));
    assign rd_fire       = fifo_rd_ena & ~fifo_rd_empty;
    assign pop           = rd_fire & wcnt_last;
    assign fifo_wr_afull = (fifo_wr_level >= LW'(AFULL_THRESH));
    assign sel           = (WORD_ORDER == WORD_MS_FIRST) ? (WCW'(N - 1) - wcnt_q) : wcnt_q;

    always_comb begin
        wcnt_d = wcnt_q;
        if (fifo_flush)     wcnt_d = '0;
        else if (rd_fire)   wcnt_d = wcnt_last ? '0 : wcnt_q + WCW'(1);
    end

    always_ff @(posedge fifo_clk or posedge fifo_arst) begin
        if (fifo_arst) wcnt_q <= '0;
        else           wcnt_q <= wcnt_d;
    end

    // Outputs are forced to zero while empty so unreset storage never leaks out.
    always_comb begin
        fifo_rd_dout = '0;
        fifo_rd_strb = '0;
        fifo_rd_last = 1'b0;
        if (!fifo_rd_empty) begin
            for (int k = 0; k < N; k++) begin
                if (sel == WCW'(k)) begin
                    fifo_rd_dout = head_din[k*HB_WORD_W +: HB_WORD_W];
                    fifo_rd_strb = head_strb[k*HB_STRB_W +: HB_STRB_W];
                end
            end
            fifo_rd_last = wcnt_last;
        end
    end

endmodule

// File: tb/tb_hbmc_dfifo_sc.sv
// Bench for hbmc_dfifo_sc: 32-bit LS-first depth-4 instance with a word scoreboard,
// plus a 64-bit MS-first instance for word ordering.
module tb_hbmc_dfifo_sc;

    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic arst;

    logic        a_flush, a_wr_ena, a_rd_ena;
    logic [31:0] a_din;
    logic [3:0]  a_strb;
    logic        a_full, a_afull, a_last, a_empty;
    logic [2:0]  a_level;
    logic [15:0] a_dout;
    logic [1:0]  a_rstrb;

    logic        b_flush, b_wr_ena, b_rd_ena;
    logic [63:0] b_din;
    logic [7:0]  b_strb;
    logic        b_full, b_afull, b_last, b_empty;
    logic [2:0]  b_level;
    logic [15:0] b_dout;
    logic [1:0]  b_rstrb;

    int errors = 0;
    int checks = 0;

    logic [18:0] sb [$];
    int          m_lvl = 0;
    logic        acc_a;

    hbmc_dfifo_sc #(
        .DATA_WIDTH (32),
        .FIFO_DEPTH (4),
        .WORD_ORDER (hbmc_dfifo_pkg::WORD_LS_FIRST)
    ) u_dut_a (
        .fifo_clk      (clk),
        .fifo_arst     (arst),
        .fifo_flush    (a_flush),
        .fifo_wr_din   (a_din),
        .fifo_wr_strb  (a_strb),
        .fifo_wr_ena   (a_wr_ena),
        .fifo_wr_full  (a_full),
        .fifo_wr_afull (a_afull),
        .fifo_wr_level (a_level),
        .fifo_rd_dout  (a_dout),
        .fifo_rd_strb  (a_rstrb),
        .fifo_rd_last  (a_last),
        .fifo_rd_ena   (a_rd_ena),
        .fifo_rd_empty (a_empty)
    );

    hbmc_dfifo_sc #(
        .DATA_WIDTH (64),
        .FIFO_DEPTH (4),
        .WORD_ORDER (hbmc_dfifo_pkg::WORD_MS_FIRST)
    ) u_dut_b (
        .fifo_clk      (clk),
        .fifo_arst     (arst),
        .fifo_flush    (b_flush),
        .fifo_wr_din   (b_din),
        .fifo_wr_strb  (b_strb),
        .fifo_wr_ena   (b_wr_ena),
        .fifo_wr_full  (b_full),
        .fifo_wr_afull (b_afull),
        .fifo_wr_level (b_level),
        .fifo_rd_dout  (b_dout),
        .fifo_rd_strb  (b_rstrb),
        .fifo_rd_last  (b_last),
        .fifo_rd_ena   (b_rd_ena),
        .fifo_rd_empty (b_empty)
    );

    // Drive one cycle on instance A and update the word scoreboard from pre-edge state.
    task automatic drive_a(input logic wr, input logic [31:0] din, input logic [3:0] st,
                           input logic rd, input logic fl);
        logic push_m, fire_m;
        a_wr_ena = wr; a_din = din; a_strb = st; a_rd_ena = rd; a_flush = fl;
        push_m = wr && (m_lvl != 4);
        fire_m = rd && (m_lvl != 0);
        acc_a  = 1'b0;
        if (fl) begin
            sb.delete();
            m_lvl = 0;
        end else begin
            if (fire_m) begin
                if (sb[0][0]) m_lvl--;
                void'(sb.pop_front());
            end
            if (push_m) begin
                sb.push_back({din[15:0], st[1:0], 1'b0});
                sb.push_back({din[31:16], st[3:2], 1'b1});
                m_lvl++;
                acc_a = 1'b1;
            end
        end
        @(posedge clk); #1;
        a_wr_ena = 1'b0; a_rd_ena = 1'b0; a_flush = 1'b0;
    endtask

    task automatic test_reset();
        arst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        checks++; if (a_empty !== 1'b1) begin errors++; $display("FAIL reset_empty: got %b want 1", a_empty); end
        checks++; if (a_full !== 1'b0) begin errors++; $display("FAIL reset_full: got %b want 0", a_full); end
        checks++; if (a_afull !== 1'b0) begin errors++; $display("FAIL reset_afull: got %b want 0", a_afull); end
        checks++; if (a_level !== 3'd0) begin errors++; $display("FAIL reset_level: got %0d want 0", a_level); end
        checks++; if ({a_dout, a_rstrb, a_last} !== 19'h0) begin errors++; $display("FAIL reset_outputs: got %h/%b/%b want 0", a_dout, a_rstrb, a_last); end
        checks++; if (b_empty !== 1'b1) begin errors++; $display("FAIL reset_b_empty: got %b want 1", b_empty); end
        arst = 1'b0;
        @(posedge clk); #1;
        checks++; if (a_empty !== 1'b1) begin errors++; $display("FAIL post_reset_empty: got %b want 1", a_empty); end
    endtask

    task automatic test_ls_words();
        drive_a(1'b1, 32'hBEEF_CAFE, 4'b1101, 1'b0, 1'b0);
        checks++; if (a_empty !== 1'b0) begin errors++; $display("FAIL ls_empty: got %b want 0", a_empty); end
        checks++; if ({a_dout, a_rstrb, a_last} !== {16'hCAFE, 2'b01, 1'b0}) begin errors++; $display("FAIL ls_word0: got %h/%b/%b want cafe/01/0", a_dout, a_rstrb, a_last); end
        checks++; if (a_level !== 3'd1) begin errors++; $display("FAIL ls_level: got %0d want 1", a_level); end
        drive_a(1'b0, 32'h0, 4'h0, 1'b1, 1'b0);
        checks++; if ({a_dout, a_rstrb, a_last} !== {16'hBEEF, 2'b11, 1'b1}) begin errors++; $display("FAIL ls_word1: got %h/%b/%b want beef/11/1", a_dout, a_rstrb, a_last); end
        drive_a(1'b0, 32'h0, 4'h0, 1'b1, 1'b0);
        checks++; if (a_empty !== 1'b1 || a_level !== 3'd0) begin errors++; $display("FAIL ls_drain: got empty=%b level=%0d want 1/0", a_empty, a_level); end
        drive_a(1'b0, 32'h0, 4'h0, 1'b1, 1'b0);
        checks++; if (a_empty !== 1'b1 || a_dout !== 16'h0) begin errors++; $display("FAIL ls_read_empty: got empty=%b dout=%h want 1/0", a_empty, a_dout); end
    endtask

    task automatic test_ms_order();
        logic [1:0]  es [4] = '{2'b01, 2'b10, 2'b11, 2'b00};
        logic [15:0] ew;
        b_din = 64'h0004_0003_0002_0001; b_strb = 8'b01_10_11_00; b_wr_ena = 1'b1;
        @(posedge clk); #1;
        b_wr_ena = 1'b0;
        for (int i = 0; i < 4; i++) begin
            ew = 16'(4 - i);
            checks++;
            if ({b_empty, b_dout, b_rstrb, b_last} !== {1'b0, ew, es[i], (i == 3)}) begin
                errors++;
                $display("FAIL ms_word%0d: got e=%b %h/%b/%b want 0 %h/%b/%b", i, b_empty, b_dout, b_rstrb, b_last, ew, es[i], (i == 3));
            end
            b_rd_ena = 1'b1;
            @(posedge clk); #1;
            b_rd_ena = 1'b0;
        end
        checks++; if (b_empty !== 1'b1) begin errors++; $display("FAIL ms_drain: got %b want 1", b_empty); end
    endtask

    task automatic test_fill();
        int exp_l;
        int budget;
        for (int i = 0; i < 5; i++) begin
            drive_a(1'b1, {16'(16'h1101 + 2*i), 16'(16'h1100 + 2*i)}, 4'(i + 5), 1'b0, 1'b0);
            exp_l = (i < 4) ? i + 1 : 4;
            checks++;
            if (a_level !== 3'(exp_l) || a_full !== (exp_l == 4) || a_afull !== (exp_l >= 2)) begin
                errors++;
                $display("FAIL fill_push%0d: got lvl=%0d full=%b afull=%b want %0d/%b/%b", i, a_level, a_full, a_afull, exp_l, (exp_l == 4), (exp_l >= 2));
            end
        end
        checks++; if (sb.size() != 8) begin errors++; $display("FAIL fill_accepted: got %0d words want 8", sb.size()); end
        budget = 0;
        while (sb.size() > 0 && budget < 20) begin
            checks++;
            if ({a_dout, a_rstrb, a_last} !== sb[0]) begin errors++; $display("FAIL fill_read: got %h want %h", {a_dout, a_rstrb, a_last}, sb[0]); end
            drive_a(1'b0, 32'h0, 4'h0, 1'b1, 1'b0);
            budget++;
        end
        checks++; if (a_empty !== 1'b1 || budget != 8) begin errors++; $display("FAIL fill_drain: got empty=%b reads=%0d want 1/8", a_empty, budget); end
    endtask

    task automatic test_full_concurrent();
        int pushed;
        int cyc;
        for (int i = 0; i < 4; i++) drive_a(1'b1, {16'(16'h2201 + 2*i), 16'(16'h2200 + 2*i)}, 4'hF, 1'b0, 1'b0);
        drive_a(1'b0, 32'h0, 4'h0, 1'b1, 1'b0);
        checks++; if (a_last !== 1'b1 || a_full !== 1'b1) begin errors++; $display("FAIL full_pre: got last=%b full=%b want 1/1", a_last, a_full); end
        drive_a(1'b1, 32'hDEAD_DEAD, 4'hF, 1'b1, 1'b0);
        checks++; if (a_level !== 3'd3 || a_full !== 1'b0) begin errors++; $display("FAIL full_drop: got lvl=%0d full=%b want 3/0", a_level, a_full); end
        checks++; if ({a_dout, a_rstrb, a_last} !== {16'h2202, 2'b11, 1'b0}) begin errors++; $display("FAIL full_head: got %h want 2202/11/0", a_dout); end
        pushed = 0;
        cyc = 0;
        while ((pushed < 20 || sb.size() > 0) && cyc < 400) begin
            drive_a(pushed < 20, {16'(16'h5001 + 2*pushed), 16'(16'h5000 + 2*pushed)}, 4'(pushed),
                    ($urandom_range(0, 3) != 0), 1'b0);
            if (acc_a) pushed++;
            cyc++;
            checks++;
            if ({a_dout, a_rstrb, a_last} !== ((sb.size() > 0) ? sb[0] : 19'h0) || a_level !== 3'(m_lvl)) begin
                errors++;
                $display("FAIL stream_c%0d: got %h lvl=%0d want %h lvl=%0d", cyc, {a_dout, a_rstrb, a_last}, a_level, (sb.size() > 0) ? sb[0] : 19'h0, m_lvl);
            end
        end
        checks++; if (cyc >= 400 || a_empty !== 1'b1) begin errors++; $display("FAIL stream_timeout: got cycles=%0d empty=%b want <400/1", cyc, a_empty); end
    endtask

    task automatic test_flush();
        drive_a(1'b1, 32'h3333_2222, 4'hF, 1'b0, 1'b0);
        drive_a(1'b1, 32'h5555_4444, 4'hF, 1'b0, 1'b0);
        drive_a(1'b0, 32'h0, 4'h0, 1'b1, 1'b0);
        drive_a(1'b1, 32'hAAAA_BBBB, 4'hF, 1'b1, 1'b1);
        checks++; if (a_empty !== 1'b1 || a_level !== 3'd0) begin errors++; $display("FAIL flush_state: got empty=%b lvl=%0d want 1/0", a_empty, a_level); end
        checks++; if ({a_dout, a_rstrb, a_last} !== 19'h0) begin errors++; $display("FAIL flush_outputs: got %h want 0", {a_dout, a_rstrb, a_last}); end
        drive_a(1'b1, 32'h7777_6666, 4'b0110, 1'b0, 1'b0);
        checks++; if ({a_dout, a_rstrb, a_last} !== {16'h6666, 2'b10, 1'b0}) begin errors++; $display("FAIL flush_next: got %h/%b/%b want 6666/10/0", a_dout, a_rstrb, a_last); end
        drive_a(1'b0, 32'h0, 4'h0, 1'b1, 1'b0);
        checks++; if ({a_dout, a_rstrb, a_last} !== {16'h7777, 2'b01, 1'b1}) begin errors++; $display("FAIL flush_next_w1: got %h/%b/%b want 7777/01/1", a_dout, a_rstrb, a_last); end
        drive_a(1'b0, 32'h0, 4'h0, 1'b1, 1'b0);
    endtask

    task automatic test_reset_mid();
        drive_a(1'b1, 32'h1234_5678, 4'hF, 1'b0, 1'b0);
        drive_a(1'b0, 32'h0, 4'h0, 1'b1, 1'b0);
        #2 arst = 1'b1;
        #1;
        checks++; if (a_empty !== 1'b1 || a_level !== 3'd0 || a_dout !== 16'h0) begin errors++; $display("FAIL arst_async: got empty=%b lvl=%0d dout=%h want 1/0/0", a_empty, a_level, a_dout); end
        sb.delete();
        m_lvl = 0;
        @(posedge clk); #1;
        arst = 1'b0;
        @(posedge clk); #1;
        checks++; if (a_empty !== 1'b1) begin errors++; $display("FAIL arst_residual: got empty=%b want 1", a_empty); end
        drive_a(1'b1, 32'h9ABC_DEF0, 4'b0011, 1'b0, 1'b0);
        checks++; if ({a_dout, a_rstrb, a_last} !== {16'hDEF0, 2'b11, 1'b0}) begin errors++; $display("FAIL arst_next: got %h/%b/%b want def0/11/0", a_dout, a_rstrb, a_last); end
    endtask

    initial begin
        arst = 1'b1;
        a_flush = 1'b0; a_wr_ena = 1'b0; a_rd_ena = 1'b0; a_din = '0; a_strb = '0;
        b_flush = 1'b0; b_wr_ena = 1'b0; b_rd_ena = 1'b0; b_din = '0; b_strb = '0;
        test_reset();
        test_ls_words();
        test_ms_order();
        test_fill();
        test_full_concurrent();
        test_flush();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
